// File: rtl/fec_conv_encoder.sv
// Rate-1/2 terminated convolutional encoder: one DATA_W-bit word per req/ack
// transaction, encoded MSB-first with K-1 zero tail bits, packed into code_out.
module fec_conv_encoder #(
    parameter int             DATA_W = 8,
    parameter int             K      = 3,
    parameter logic [K-1:0]   G0     = 3'b111,
    parameter logic [K-1:0]   G1     = 3'b101,
    localparam int            CODE_W = 2 * (DATA_W + K - 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack,
    output logic              busy,
    output logic [CODE_W-1:0] code_out
);

    localparam int SR_W  = K - 1;
    localparam int CNT_W = $clog2((DATA_W > K) ? DATA_W : K) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        TAIL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CODE_W-1:0]   acc_q, acc_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                enc_bit;
    logic [K-1:0]        taps;
    logic                c0;
    logic                c1;
    logic [SR_W-1:0]     sr_shift;
    logic [CODE_W-1:0]   acc_shift;

    // The latched word is shifted left as it is consumed, so its MSB is
    // always the next bit to encode; tail cycles feed zeros.
    always_comb begin
        enc_bit   = (state_q == ENCODE) ? data_q[DATA_W-1] : 1'b0;
        taps      = {enc_bit, sr_q};
        c0        = ^(G0 & taps);
        c1        = ^(G1 & taps);
        sr_shift  = SR_W'(taps >> 1);
        acc_shift = {acc_q[CODE_W-3:0], c0, c1};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        acc_d   = acc_q;
        code_d  = code_q;
        ack_d   = ack_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    data_d  = data_in;
                    sr_d    = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ENCODE;
                end
            end

            ENCODE: begin
                data_d = data_q << 1;
                sr_d   = sr_shift;
                acc_d  = acc_shift;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = TAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            TAIL: begin
                sr_d  = sr_shift;
                acc_d = acc_shift;
                // The final tail pair goes straight into code_out alongside the accumulator.
                if (cnt_q == CNT_W'(K - 2)) begin
                    cnt_d   = '0;
                    code_d  = acc_shift;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                ack_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            code_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            code_q  <= code_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign code_out = code_q;

endmodule

// File: tb/tb_fec_conv_encoder.sv
// Directed bench for fec_conv_encoder with hand-computed (7,5) codewords.
module tb_fec_conv_encoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic        req;
    logic [7:0]  data_in;
    logic        ack;
    logic        busy;
    logic [19:0] code_out;

    int compared;
    int mismatched;

    fec_conv_encoder #(
        .DATA_W (8),
        .K      (3),
        .G0     (3'b111),
        .G1     (3'b101)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .busy     (busy),
        .code_out (code_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts from IDLE at #1 after an edge; returns edges from the accepting
    // edge to ack, busy-high samples up to ack, and the codeword at ack.
    task automatic send_word(input logic [7:0] d, output int lat, output int busy_cnt,
                             output logic [19:0] code);
        req     = 1'b1;
        data_in = d;
        step();
        req      = 1'b0;
        data_in  = ~d;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!ack && lat < 40) begin
            step();
            lat++;
            if (busy) busy_cnt++;
        end
        code = code_out;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        req     = 1'b1;
        data_in = 8'hB0;
        for (int i = 0; i < 2; i++) begin
            step();
            compared++;
            if (busy !== 1'b0 || ack !== 1'b0 || code_out !== 20'h00000) begin
                mismatched++;
                $display("[TB] FAIL reset_hold: ack=%b busy=%b code=%h, expected 0/0/00000", ack, busy, code_out);
            end
        end
        rst = 1'b0;
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if (busy !== 1'b0 || ack !== 1'b0 || code_out !== 20'h00000) begin
                mismatched++;
                $display("[TB] FAIL reset_idle: ack=%b busy=%b code=%h, expected 0/0/00000", ack, busy, code_out);
            end
        end
    endtask

    task automatic test_single();
        int lat, bcnt;
        logic [19:0] code;
        send_word(8'hB0, lat, bcnt, code);
        compared++;
        if (lat !== 10) begin
            mismatched++;
            $display("[TB] FAIL single_latency: got %0d edges, expected 10", lat);
        end
        compared++;
        if (code !== 20'hE1700) begin
            mismatched++;
            $display("[TB] FAIL single_code: got %h, expected E1700", code);
        end
        step();
        compared++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_end: ack=%b busy=%b, expected 0/0", ack, busy);
        end
        compared++;
        if (bcnt !== 11) begin
            mismatched++;
            $display("[TB] FAIL single_busy: busy for %0d cycles, expected 11", bcnt);
        end
        compared++;
        if (code_out !== 20'hE1700) begin
            mismatched++;
            $display("[TB] FAIL single_hold: got %h, expected E1700", code_out);
        end
    endtask

    task automatic test_impulse();
        int lat, bcnt;
        logic [19:0] code;
        send_word(8'h80, lat, bcnt, code);
        compared++;
        if (code !== 20'hEC000 || lat !== 10) begin
            mismatched++;
            $display("[TB] FAIL impulse_code: got %h lat %0d, expected EC000 lat 10", code, lat);
        end
        step();
        req     = 1'b1;
        data_in = 8'h00;
        step();
        req = 1'b0;
        compared++;
        if (code_out !== 20'hEC000 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL impulse_hold: code=%h busy=%b, expected EC000/1", code_out, busy);
        end
        lat = 0;
        while (!ack && lat < 40) begin
            step();
            lat++;
        end
        compared++;
        if (code_out !== 20'h00000 || lat !== 10) begin
            mismatched++;
            $display("[TB] FAIL zero_code: got %h lat %0d, expected 00000 lat 10", code_out, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int first_ack, second_ack, n_acks;
        logic [19:0] code1, code2;
        first_ack  = 0;
        second_ack = 0;
        n_acks     = 0;
        code1      = '0;
        code2      = '0;
        req     = 1'b1;
        data_in = 8'hB0;
        step();
        data_in = 8'h80;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (ack) begin
                n_acks++;
                if (first_ack == 0) begin
                    first_ack = t;
                    code1     = code_out;
                end else if (second_ack == 0) begin
                    second_ack = t;
                    code2      = code_out;
                end
            end
            if (first_ack != 0 && t > first_ack && busy) req = 1'b0;
        end
        req = 1'b0;
        compared++;
        if (first_ack !== 10 || code1 !== 20'hE1700) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: ack at %0d code %h, expected 10 E1700", first_ack, code1);
        end
        compared++;
        if (second_ack !== 22 || code2 !== 20'hEC000) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: ack at %0d code %h, expected 22 EC000", second_ack, code2);
        end
        compared++;
        if (n_acks !== 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: %0d acks, expected 2", n_acks);
        end
    endtask

    task automatic test_enable();
        int lat;
        req     = 1'b1;
        data_in = 8'hB0;
        step();
        req     = 1'b0;
        data_in = 8'hFF;
        lat     = 0;
        repeat (3) begin
            step();
            lat++;
        end
        en = 1'b0;
        repeat (3) begin
            step();
            lat++;
        end
        en = 1'b1;
        while (!ack && lat < 40) begin
            step();
            lat++;
        end
        compared++;
        if (lat !== 13 || code_out !== 20'hE1700) begin
            mismatched++;
            $display("[TB] FAIL en_encode: ack at %0d code %h, expected 13 E1700", lat, code_out);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (ack !== 1'b1 || busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL en_done_hold: ack=%b busy=%b, expected 1/1", ack, busy);
            end
        end
        en = 1'b1;
        step();
        compared++;
        if (ack !== 1'b0 || busy !== 1'b0 || code_out !== 20'hE1700) begin
            mismatched++;
            $display("[TB] FAIL en_done_exit: ack=%b busy=%b code=%h, expected 0/0/E1700", ack, busy, code_out);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, stray;
        logic [19:0] code;
        req     = 1'b1;
        data_in = 8'hB0;
        step();
        req = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if (ack !== 1'b0 || busy !== 1'b0 || code_out !== 20'h00000) begin
            mismatched++;
            $display("[TB] FAIL abort_state: ack=%b busy=%b code=%h, expected 0/0/00000", ack, busy, code_out);
        end
        stray = 0;
        repeat (12) begin
            step();
            if (ack || busy) stray++;
        end
        compared++;
        if (stray !== 0) begin
            mismatched++;
            $display("[TB] FAIL abort_quiet: %0d active cycles, expected 0", stray);
        end
        send_word(8'h80, lat, bcnt, code);
        compared++;
        if (lat !== 10 || code !== 20'hEC000) begin
            mismatched++;
            $display("[TB] FAIL abort_recover: lat %0d code %h, expected 10 EC000", lat, code);
        end
        step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        en         = 1'b1;
        req        = 1'b0;
        data_in    = 8'h00;
        test_reset();
        test_single();
        test_impulse();
        test_back_to_back();
        test_enable();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
